pingpong_burst_src: RTL
=======================

Name: pingpong_burst_src

Overview:
- Burst traffic source that drives the upstream write side of the ping-pong RAM controller (data_en/data_in/upstream_ready).
- Emits a programmed number of fixed-length frames of 64-bit words. Honours the controller's ready back-pressure and inserts a programmable idle gap between frames.
- Used as on-chip stimulus and for throughput measurement of the ping-pong path. Reports status counters to the control logic.

Parameters:
FRAME_LEN, 64, words per frame; must match the controller's RAM depth; legal range 1..65535
CNT_W, 32, width of the accepted-word and stall counters

Ports:
clk_50m  input  1  system clock
rst  input  1  asynchronous, active-high reset
i_start  input  1  one-cycle start pulse; ignored while o_busy=1
i_abort  input  1  abort current run; takes priority over every other event
i_frame_num  input  16  number of frames to send; latched on accepted i_start
i_gap_len  input  8  idle cycles between frames; latched on accepted i_start
i_seed  input  64  first data word (or LFSR seed); latched on accepted i_start
i_ready  input  1  upstream_ready from the ping-pong controller
o_data_en  output  1  word valid
o_data  output  64  word payload
o_frame_last  output  1  high with the final word of each frame
o_busy  output  1  run in progress
o_done  output  1  one-cycle pulse when a run completes normally
o_word_cnt  output  CNT_W  words accepted since the last accepted i_start
o_stall_cnt  output  CNT_W  cycles with o_data_en=1 and i_ready=0 since the last accepted i_start

Behaviour:
- Reset values: all outputs 0. State IDLE. Latched config 0.
- Transfer rule: a word is accepted on a rising edge where o_data_en=1 and i_ready=1.
  - While o_data_en=1 and i_ready=0, o_data and o_frame_last hold stable and o_data_en stays high.
  - o_data_en never drops before acceptance, except on abort or reset.
- All outputs are registered. Latency: o_data_en rises 1 cycle after an accepted i_start.
- State machine:
  - IDLE:
    - i_start with i_frame_num>0: latch config, clear counters, set o_busy, go to SEND.
    - i_start with i_frame_num=0: clear counters, pulse o_done the next cycle, stay IDLE.
  - SEND: o_data_en=1. Word index counts 0..FRAME_LEN-1 on acceptance. o_frame_last=1 when index=FRAME_LEN-1. When the last word is accepted:
    - frames remaining >0 and gap>0: go to GAP.
    - frames remaining >0 and gap=0: stay in SEND with the next word presented in the very next cycle, with no bubble.
    - frames remaining =0: go to DONE.
  - GAP: o_data_en=0 for exactly i_gap_len cycles, then go to SEND.
  - DONE: o_done=1 for one cycle, o_busy->0, go to IDLE.
- Data pattern (default): o_data = seed + global word index, modulo 2^64. The index is continuous across frames. Wrap from 2^64-1 to 0 is legal.
- Counters:
  - o_word_cnt increments on each acceptance.
  - o_stall_cnt increments on each stall cycle.
  - Both saturate at 2^CNT_W-1 and hold until the next accepted i_start.
- Abort: o_data_en, o_frame_last and o_busy go to 0 the cycle after i_abort; state returns to IDLE.
  - No o_done pulse.
  - Counters freeze, hold their values, and remain readable.
  - A word pending at the abort edge counts as accepted only if i_ready=1 on that same edge.
- i_start coincident with i_abort: the abort wins and the start is dropped.
- i_ready toggling during GAP or IDLE has no effect.
- Reset mid-run: immediate return to reset values; no partial state survives.

Optional Feature:
Macro PINGPONG_BURST_SRC_LFSR_EN.
- Defined: o_data comes from a 64-bit Galois LFSR, polynomial x^64+x^63+x^61+x^60+1, shifting once per accepted word.
  - The first word is the seed.
  - A seed of 0 is replaced with 64'h1.
- Not defined: incrementing pattern as above, and no LFSR logic is synthesised.

Test Plan:
1. FRAME_LEN=64, frames=2, gap=4, seed=0x100, i_ready=1 -> 128 accepted words 0x100..0x17F; o_frame_last on 0x13F and 0x17F; 4 idle cycles between frames; o_done 1 cycle after the last word; o_word_cnt=128, o_stall_cnt=0.
2. Same run with i_ready low for cycles 10..14 of frame 1 -> the word at the stall is held for 5 cycles; sequence is unchanged; o_stall_cnt=5.
3. frames=3, gap=0, back-to-back into the ping-pong controller -> no bubble between frames; the controller receives 192 words in order; the stalls reported equal the cycles it deasserted ready.
4. Abort asserted during word 20 of frame 1 while stalled -> o_data_en=0 next cycle; o_busy=0; no o_done; o_word_cnt=20.
5. i_frame_num=0 with i_start -> o_done pulse after 1 cycle; o_data_en never rises; counters are 0.
6. LFSR build, seed=0 -> first word 0x1; the second word equals one Galois shift of 0x1; the sequence advances only on accepted words under random i_ready.

Source files
------------

// File: rtl/pingpong_burst_src.sv
// Burst traffic source for the ping-pong RAM controller write port: fixed-length frames, ready back-pressure, idle gaps.
// Optional macro PINGPONG_BURST_SRC_LFSR_EN swaps the incrementing payload for a 64-bit Galois LFSR.
module pingpong_burst_src #(
    parameter int FRAME_LEN = 64,
    parameter int CNT_W     = 32
) (
    input  logic             clk_50m,
    input  logic             rst,
    input  logic             i_start,
    input  logic             i_abort,
    input  logic [15:0]      i_frame_num,
    input  logic [7:0]       i_gap_len,
    input  logic [63:0]      i_seed,
    input  logic             i_ready,
    output logic             o_data_en,
    output logic [63:0]      o_data,
    output logic             o_frame_last,
    output logic             o_busy,
    output logic             o_done,
    output logic [CNT_W-1:0] o_word_cnt,
    output logic [CNT_W-1:0] o_stall_cnt
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_GAP  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    localparam logic [15:0]      LAST_IDX = 16'(FRAME_LEN - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
    localparam logic             ONE_WORD = (LAST_IDX == 16'd0);

`ifdef PINGPONG_BURST_SRC_LFSR_EN
    // Right-shifting Galois form of x^64+x^63+x^61+x^60+1.
    localparam logic [63:0] LFSR_TAPS = 64'hD800_0000_0000_0000;

    function automatic logic [63:0] next_word(input logic [63:0] cur);
        next_word = cur[0] ? ((cur >> 1) ^ LFSR_TAPS) : (cur >> 1);
    endfunction

    function automatic logic [63:0] first_word(input logic [63:0] seed);
        first_word = (seed == 64'd0) ? 64'd1 : seed;
    endfunction
`else
    function automatic logic [63:0] next_word(input logic [63:0] cur);
        next_word = cur + 64'd1;
    endfunction

    function automatic logic [63:0] first_word(input logic [63:0] seed);
        first_word = seed;
    endfunction
`endif

    state_t           state_r, state_s;
    logic [15:0]      idx_r, idx_s;
    logic [15:0]      frames_left_r, frames_left_s;
    logic [7:0]       gap_len_r, gap_len_s;
    logic [7:0]       gap_cnt_r, gap_cnt_s;
    logic             data_en_s, frame_last_s, busy_s, done_s;
    logic [63:0]      data_s;
    logic [CNT_W-1:0] word_cnt_s, stall_cnt_s;

    logic accept_s, stall_s, frame_end_s, last_frame_s, start_ok_s;

    assign accept_s     = o_data_en & i_ready;
    assign stall_s      = o_data_en & ~i_ready;
    assign frame_end_s  = accept_s & (idx_r == LAST_IDX);
    assign last_frame_s = (frames_left_r == 16'd1);
    assign start_ok_s   = i_start & ((state_r == ST_IDLE) | (state_r == ST_DONE));

    // State register.
    always_ff @(posedge clk_50m or posedge rst) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state decode; abort overrides every other event.
    always_comb begin
        state_s = state_r;
        if (i_abort) begin
            state_s = ST_IDLE;
        end else begin
            case (state_r)
                ST_IDLE, ST_DONE: begin
                    if (start_ok_s && (i_frame_num != 16'd0)) begin
                        state_s = ST_SEND;
                    end else begin
                        state_s = ST_IDLE;
                    end
                end
                ST_SEND: begin
                    if (!frame_end_s) begin
                        state_s = ST_SEND;
                    end else if (last_frame_s) begin
                        state_s = ST_DONE;
                    end else if (gap_len_r != 8'd0) begin
                        state_s = ST_GAP;
                    end else begin
                        state_s = ST_SEND;
                    end
                end
                ST_GAP: begin
                    if (gap_cnt_r == 8'd1) begin
                        state_s = ST_SEND;
                    end else begin
                        state_s = ST_GAP;
                    end
                end
                default: state_s = ST_IDLE;
            endcase
        end
    end

    // Next values of the registered outputs and datapath.
    always_comb begin
        idx_s         = idx_r;
        frames_left_s = frames_left_r;
        gap_len_s     = gap_len_r;
        gap_cnt_s     = gap_cnt_r;
        data_en_s     = o_data_en;
        data_s        = o_data;
        frame_last_s  = o_frame_last;
        busy_s        = o_busy;
        done_s        = 1'b0;
        word_cnt_s    = o_word_cnt;
        stall_cnt_s   = o_stall_cnt;

        // A word pending on an abort edge still counts if it was accepted.
        if (accept_s && (o_word_cnt != CNT_MAX)) begin
            word_cnt_s = o_word_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            word_cnt_s = o_word_cnt;
        end
        if (stall_s && (o_stall_cnt != CNT_MAX)) begin
            stall_cnt_s = o_stall_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            stall_cnt_s = o_stall_cnt;
        end

        if (i_abort) begin
            data_en_s    = 1'b0;
            frame_last_s = 1'b0;
            busy_s       = 1'b0;
        end else begin
            case (state_r)
                ST_IDLE, ST_DONE: begin
                    if (start_ok_s) begin
                        word_cnt_s  = '0;
                        stall_cnt_s = '0;
                        if (i_frame_num != 16'd0) begin
                            frames_left_s = i_frame_num;
                            gap_len_s     = i_gap_len;
                            gap_cnt_s     = 8'd0;
                            idx_s         = 16'd0;
                            data_s        = first_word(i_seed);
                            data_en_s     = 1'b1;
                            frame_last_s  = ONE_WORD;
                            busy_s        = 1'b1;
                        end else begin
                            done_s = 1'b1;
                        end
                    end else begin
                        done_s = 1'b0;
                    end
                end
                ST_SEND: begin
                    if (accept_s) begin
                        data_s = next_word(o_data);
                        if (idx_r == LAST_IDX) begin
                            idx_s         = 16'd0;
                            frames_left_s = frames_left_r - 16'd1;
                            if (last_frame_s) begin
                                data_en_s    = 1'b0;
                                frame_last_s = 1'b0;
                                busy_s       = 1'b0;
                                done_s       = 1'b1;
                            end else if (gap_len_r != 8'd0) begin
                                data_en_s    = 1'b0;
                                frame_last_s = 1'b0;
                                gap_cnt_s    = gap_len_r;
                            end else begin
                                frame_last_s = ONE_WORD;
                            end
                        end else begin
                            idx_s        = idx_r + 16'd1;
                            frame_last_s = ((idx_r + 16'd1) == LAST_IDX);
                        end
                    end else begin
                        data_s = o_data;
                    end
                end
                ST_GAP: begin
                    if (gap_cnt_r == 8'd1) begin
                        gap_cnt_s    = 8'd0;
                        data_en_s    = 1'b1;
                        frame_last_s = ONE_WORD;
                    end else begin
                        gap_cnt_s = gap_cnt_r - 8'd1;
                    end
                end
                default: begin
                    data_en_s    = 1'b0;
                    frame_last_s = 1'b0;
                    busy_s       = 1'b0;
                end
            endcase
        end
    end

    // Output and datapath registers.
    always_ff @(posedge clk_50m or posedge rst) begin
        if (rst) begin
            idx_r         <= 16'd0;
            frames_left_r <= 16'd0;
            gap_len_r     <= 8'd0;
            gap_cnt_r     <= 8'd0;
            o_data_en     <= 1'b0;
            o_data        <= 64'd0;
            o_frame_last  <= 1'b0;
            o_busy        <= 1'b0;
            o_done        <= 1'b0;
            o_word_cnt    <= '0;
            o_stall_cnt   <= '0;
        end else begin
            idx_r         <= idx_s;
            frames_left_r <= frames_left_s;
            gap_len_r     <= gap_len_s;
            gap_cnt_r     <= gap_cnt_s;
            o_data_en     <= data_en_s;
            o_data        <= data_s;
            o_frame_last  <= frame_last_s;
            o_busy        <= busy_s;
            o_done        <= done_s;
            o_word_cnt    <= word_cnt_s;
            o_stall_cnt   <= stall_cnt_s;
        end
    end

endmodule
